// File: rtl/terminal_dumper.sv
`default_nettype none
// terminal_dumper: scans the text buffer row by row and streams it as 8N1 UART text, CR/LF per row.
// Optional TERMINAL_DUMPER_FILTER_EN replaces non-printable captured bytes with '.'.
module terminal_dumper #(
  parameter int CLOCK_HZ = 25000000,
  parameter int BAUD     = 115200,
  parameter int COLS     = 80,
  parameter int ROWS     = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [11:0] text_addr,
  input  logic [7:0]  text_out,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);
  localparam int D  = CLOCK_HZ / BAUD;
  localparam int DW = $clog2(D);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {IDLE, READ, LATCH, SEND, EOL_CR, EOL_LF} state_t;

  state_t          state, next_state;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic [9:0]      shreg;
  logic [DW-1:0]   baud_cnt;
  logic [3:0]      bit_cnt;
  logic            abort_seen;
  logic [11:0]     addr_hold;
  logic [11:0]     cur_addr;
  logic            in_frame;
  logic            frame_end;
  logic            abort_hit;
  logic            done_next;

  function automatic logic [7:0] filter(input logic [7:0] b);
`ifdef TERMINAL_DUMPER_FILTER_EN
    return (b < 8'h20 || b >= 8'h7F) ? 8'h2E : b;
`else
    return b;
`endif
  endfunction

  assign cur_addr  = 12'(row) * 12'(COLS) + 12'(col);
  assign in_frame  = (state == SEND) || (state == EOL_CR) || (state == EOL_LF);
  assign frame_end = in_frame && (bit_cnt == 4'd9) && (baud_cnt == DW'(D - 1));
  assign abort_hit = abort_seen | abort;
  assign busy      = (state != IDLE);
  assign uart_tx   = in_frame ? shreg[0] : 1'b1;
  // Address is only driven fresh in READ; otherwise the last presented address is held.
  assign text_addr = (state == READ) ? cur_addr : addr_hold;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    done_next  = 1'b0;
    case (state)
      IDLE:   if (start) next_state = READ;
      READ:   next_state = LATCH;
      LATCH:  next_state = SEND;
      SEND:
        if (frame_end) begin
          if (abort_hit)                 next_state = IDLE;
          else if (col < CW'(COLS - 1))  next_state = READ;
          else                           next_state = EOL_CR;
        end
      EOL_CR: if (frame_end) next_state = EOL_LF;
      EOL_LF:
        if (frame_end) begin
          if (abort_hit)                 next_state = IDLE;
          else if (row < RW'(ROWS - 1))  next_state = READ;
          else begin
            next_state = IDLE;
            done_next  = 1'b1;
          end
        end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row        <= '0;
      col        <= '0;
      shreg      <= '1;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      abort_seen <= 1'b0;
      addr_hold  <= '0;
      done       <= 1'b0;
    end else begin
      done <= done_next;
      if (state != IDLE && next_state == IDLE) abort_seen <= 1'b0;
      else if (busy && abort)                  abort_seen <= 1'b1;
      if (state == READ) addr_hold <= cur_addr;
      if (state == IDLE) begin
        row <= '0;
        col <= '0;
      end
      if (state == LATCH) begin
        shreg    <= {1'b1, filter(text_out), 1'b0};
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end
      if (in_frame) begin
        if (frame_end) begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (state == SEND && next_state == READ)   col <= col + 1'b1;
          if (state == SEND && next_state == EOL_CR) shreg <= {1'b1, 8'h0D, 1'b0};
          if (state == EOL_CR)                       shreg <= {1'b1, 8'h0A, 1'b0};
          if (state == EOL_LF && next_state == READ) begin
            row <= row + 1'b1;
            col <= '0;
          end
        end else if (baud_cnt == DW'(D - 1)) begin
          baud_cnt <= '0;
          bit_cnt  <= bit_cnt + 4'd1;
          shreg    <= {1'b1, shreg[9:1]};
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: doc/terminal_dumper.md
# terminal_dumper

Read-side companion to the terminal text buffer. The debugger writes characters into the buffer. This block scans the buffer row by row through the buffer's synchronous read port and serialises every character over an 8N1 UART transmit line, appending CR/LF at each row end, so a host can capture the screen contents as text. It sits beside the terminal and runs on the 25 MHz pixel/debugger clock domain; arbitration of the shared text address port is done outside this block.

## Interface
- CLOCK_HZ, 25000000: frequency of clock in Hz
- BAUD, 115200: serial bit rate; D = CLOCK_HZ/BAUD (integer, truncated) clock cycles per bit, D ≥ 2
- COLS, 80: characters per row
- ROWS, 30: rows per screen; COLS*ROWS ≤ 4096
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request a full-screen dump; sampled only in IDLE
- abort  in  1  stop the dump after the current UART frame completes
- text_addr  out  12  buffer read address
- text_out  in  8  buffer read data, valid one clock after text_addr is presented
- uart_tx  out  1  serial line; idles high
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse when a dump completes without abort

## Operation
- Reset values: busy=0, done=0, text_addr=0, uart_tx=1. The FSM goes to IDLE and row/col are cleared. All are asynchronous, so a reset mid-frame truncates the line immediately.
- States: IDLE, READ, LATCH, SEND, EOL_CR, EOL_LF.
- IDLE: row=col=0. If start=1, go to READ.
- READ: text_addr = row*COLS+col, computed as a 12-bit unsigned value. Go to LATCH.
- LATCH: capture text_out, apply the filter (see Configuration), and load the shift register with the frame {1, byte, 0}. Go to SEND.
- SEND: shift out the 10 bits LSB-first, holding each bit for D cycles. The sequence is start bit 0, data bits d0..d7, then stop bit 1. At frame end:
  - abort seen since the frame began: go to IDLE.
  - col < COLS-1: col++, go to READ.
  - otherwise: go to EOL_CR.
- EOL_CR: send 0x0D as a 10·D-cycle frame, then go to EOL_LF.
- EOL_LF: send 0x0A. At frame end:
  - abort seen: go to IDLE.
  - row < ROWS-1: row++, col=0, go to READ.
  - otherwise: go to IDLE and pulse done.
- abort is latched whenever busy=1 and cleared on entry to IDLE. An aborted dump never pulses done.
- start is ignored whenever busy=1.
- text_addr holds its last value outside READ.

## Timing
- Cycle 0: start sampled high in IDLE.
- Cycle 1: READ, busy=1, text_addr=0.
- Cycle 2: LATCH.
- Cycle 3: start bit begins.
- Each character costs 10·D+2 cycles (READ + LATCH + frame); uart_tx=1 during READ and LATCH. CR and LF each cost exactly 10·D, back to back with no gap.
- T = ROWS·(COLS·(10·D+2) + 20·D). The final stop bit ends at cycle T. At cycle T+1 the FSM is in IDLE with done=1 and busy=0.
- start high on the same cycle done=1 is accepted; that cycle counts as cycle 0 of the new dump.
- Abort latency: the current frame always completes, which takes at most 10·D cycles. busy falls on the cycle after that frame's stop bit ends.

## Configuration
- TERMINAL_DUMPER_FILTER_EN defined: any captured byte < 0x20 or ≥ 0x7F is transmitted as 0x2E ('.'); all other bytes are sent unchanged.
- TERMINAL_DUMPER_FILTER_EN undefined: captured bytes are transmitted raw.
- CR/LF are never filtered.

## Test plan
- All tests use CLOCK_HZ=40, BAUD=10 (D=4), COLS=4, ROWS=2. The buffer model returns data one clock after the address.
- Full dump: buffer "ABCD","EFGH"; start at cycle 0 -> the line decodes 41 42 43 44 0D 0A 45 46 47 48 0D 0A; done=1 at cycle 497 only; busy=1 on cycles 1..496.
- Framing: first character 'A' -> uart_tx is 0,1,0,0,0,0,0,1,0,1, each held 4 cycles, starting at cycle 3; uart_tx=1 on cycles 1, 2, 43 and 44.
- Filter (macro defined): buffer bytes 0x07, 0x7F, 0x7E, 0x20 -> sends 2E 2E 7E 20. With the macro undefined, the same buffer sends 07 7F 7E 20.
- Busy/start: start pulsed at cycles 0 and 100 -> exactly one dump. start asserted on the done cycle -> a second dump begins at the next cycle with text_addr=0.
- Abort: abort pulsed at cycle 50 (mid-frame of 'B') -> the 'B' frame completes at cycle 84; busy=0 at cycle 85; done never pulses; a new start reads address 0.
- Reset mid-frame: reset at cycle 20 -> uart_tx=1, busy=0, and text_addr=0 in the same cycle. A subsequent start repeats the full-dump result exactly.
